cbi980_i2s_core: RTL and testbench

//  Register bank + I2S transmit engine behind the CBI980 AXI4-Lite front-end.

---
 rtl/cbi980_i2s_core.sv | 203 ++++++++++++++++++++
 tb/tb_cbi980_i2s_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cbi980_i2s_core.sv
// CBI980 register bank, sample FIFO and I2S master transmitter (16b/ch, 32 BCLK/frame).
// Optional FIFO-low / error interrupt is built when CBI980_IRQ_EN is defined.
module cbi980_i2s_core #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLKDIV_W   = 8
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic        write_en,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic        read_en,
  input  logic [31:0] read_addr,
  output logic [31:0] read_data,
  output logic        read_vld,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state_r;
  logic                en_r, irq_mask_r, underrun_r, overflow_r, irq_r;
  logic [CLKDIV_W-1:0] clkdiv_r, div_cnt_r, div_lim_r;
  logic [31:0]         read_data_r, shift_r;
  logic                read_vld_r, bclk_r, lrclk_r, sdata_r, started_r;
  logic [4:0]          bit_cnt_r;
  logic [31:0]         mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       count_r;

  logic wr_ctrl_s, wr_status_s, wr_clkdiv_s, wr_tx_s, flush_s;
  logic full_s, empty_s, push_s, pop_s, load_s, div_hit_s, fall_s;
  logic [4:0]  nxt_b_s;
  logic [8:0]  cnt9_s;
  logic [7:0]  level_s;
  logic [31:0] fifo_head_s, rd_mux_s;
  logic        unused_s;

  // Address decode, FIFO status and engine event strobes
  always_comb begin
    wr_ctrl_s   = write_en && (write_addr[3:2] == 2'd0);
    wr_status_s = write_en && (write_addr[3:2] == 2'd1);
    wr_clkdiv_s = write_en && (write_addr[3:2] == 2'd2);
    wr_tx_s     = write_en && (write_addr[3:2] == 2'd3);
    flush_s     = wr_ctrl_s && write_data[1];
    full_s      = (count_r == DEPTH_C);
    empty_s     = (count_r == {CW{1'b0}});
    push_s      = wr_tx_s && !full_s;
    div_hit_s   = (div_cnt_r == div_lim_r);
    fall_s      = (state_r == ST_RUN) && div_hit_s && bclk_r;
    nxt_b_s     = started_r ? (bit_cnt_r + 5'd1) : 5'd0;
    // A new frame is only fetched while enabled; otherwise the engine stops instead
    load_s      = fall_s && (nxt_b_s == 5'd0) && en_r;
    pop_s       = load_s && !empty_s;
    fifo_head_s = empty_s ? 32'h0000_0000 : mem_r[rd_ptr_r];
    cnt9_s      = 9'(count_r);
    level_s     = cnt9_s[8] ? 8'hFF : cnt9_s[7:0];
    unused_s    = ^{write_addr[31:4], write_addr[1:0], read_addr[31:4], read_addr[1:0]};
  end

  // Register read multiplexer
  always_comb begin
    case (read_addr[3:2])
      2'd0:    rd_mux_s = {29'd0, irq_mask_r, 1'b0, en_r};
      2'd1:    rd_mux_s = {16'h0000, level_s, 4'h0, overflow_r, underrun_r, full_s, empty_s};
      2'd2:    rd_mux_s = {{(32 - CLKDIV_W){1'b0}}, clkdiv_r};
      default: rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Control/status registers and registered read response
  always_ff @(posedge aclk) begin
    if (rst) begin
      en_r        <= 1'b0;
      irq_mask_r  <= 1'b0;
      clkdiv_r    <= {CLKDIV_W{1'b0}};
      underrun_r  <= 1'b0;
      overflow_r  <= 1'b0;
      read_vld_r  <= 1'b0;
      read_data_r <= 32'h0000_0000;
    end else begin
      if (wr_ctrl_s) begin
        en_r <= write_data[0];
`ifdef CBI980_IRQ_EN
        irq_mask_r <= write_data[2];
`else
        irq_mask_r <= 1'b0;
`endif
      end
      if (wr_clkdiv_s) clkdiv_r <= write_data[CLKDIV_W-1:0];
      // Sticky error flags: a new event wins over a simultaneous W1C
      underrun_r  <= (underrun_r & ~(wr_status_s & write_data[2])) | (load_s & empty_s);
      overflow_r  <= (overflow_r & ~(wr_status_s & write_data[3])) | (wr_tx_s & full_s);
      read_vld_r  <= read_en;
      read_data_r <= read_en ? rd_mux_s : 32'h0000_0000;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge aclk) begin
    if (rst || flush_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      count_r <= count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    end
  end

  // FIFO storage
  always_ff @(posedge aclk) begin
    if (push_s) mem_r[wr_ptr_r] <= write_data;
  end

  // I2S engine: BCLK divider, bit counter, shifter and word select
  always_ff @(posedge aclk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      div_cnt_r <= {CLKDIV_W{1'b0}};
      div_lim_r <= {CLKDIV_W{1'b0}};
      bclk_r    <= 1'b0;
      lrclk_r   <= 1'b0;
      sdata_r   <= 1'b0;
      bit_cnt_r <= 5'd0;
      started_r <= 1'b0;
      shift_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          div_cnt_r <= {CLKDIV_W{1'b0}};
          div_lim_r <= clkdiv_r;
          bclk_r    <= 1'b0;
          lrclk_r   <= 1'b0;
          sdata_r   <= 1'b0;
          bit_cnt_r <= 5'd0;
          started_r <= 1'b0;
          if (en_r) state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (div_hit_s) begin
            div_cnt_r <= {CLKDIV_W{1'b0}};
            div_lim_r <= clkdiv_r;
            bclk_r    <= ~bclk_r;
          end else begin
            div_cnt_r <= div_cnt_r + {{(CLKDIV_W-1){1'b0}}, 1'b1};
          end
          if (fall_s) begin
            if ((nxt_b_s == 5'd0) && !en_r) begin
              state_r   <= ST_IDLE;
              bclk_r    <= 1'b0;
              lrclk_r   <= 1'b0;
              sdata_r   <= 1'b0;
              bit_cnt_r <= 5'd0;
              started_r <= 1'b0;
            end else begin
              bit_cnt_r <= nxt_b_s;
              started_r <= 1'b1;
              if (nxt_b_s == 5'd0) begin
                sdata_r <= fifo_head_s[31];
                shift_r <= {fifo_head_s[30:0], 1'b0};
              end else begin
                sdata_r <= shift_r[31];
                shift_r <= {shift_r[30:0], 1'b0};
              end
              if (nxt_b_s == 5'd31)      lrclk_r <= 1'b0;
              else if (nxt_b_s == 5'd15) lrclk_r <= 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef CBI980_IRQ_EN
  localparam logic [CW-1:0] HALF_C = CW'(FIFO_DEPTH / 2);
  // Interrupt: FIFO at or below half while running, or any sticky error
  always_ff @(posedge aclk) begin
    if (rst) irq_r <= 1'b0;
    else     irq_r <= irq_mask_r & ((en_r & (count_r <= HALF_C)) | underrun_r | overflow_r);
  end
`else
  // Interrupt not built: held low
  always_ff @(posedge aclk) begin
    irq_r <= 1'b0;
  end
`endif

  assign read_data = read_data_r;
  assign read_vld  = read_vld_r;
  assign i2s_bclk  = bclk_r;
  assign i2s_lrclk = lrclk_r;
  assign i2s_sdata = sdata_r;
  assign irq       = irq_r;
endmodule

// File: tb/tb_cbi980_i2s_core.sv
// Self-checking bench for cbi980_i2s_core: register table, read scoreboard, I2S frame capture.
module tb_cbi980_i2s_core;
`ifdef CBI980_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic        write_en = 1'b0, read_en = 1'b0;
  logic [31:0] write_addr = 32'h0, write_data = 32'h0, read_addr = 32'h0;
  logic [31:0] read_data;
  logic        read_vld, i2s_bclk, i2s_lrclk, i2s_sdata, irq;

  cbi980_i2s_core dut (
    .aclk(aclk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en(read_en), .read_addr(read_addr),
    .read_data(read_data), .read_vld(read_vld),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .irq(irq)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {logic [1:0] a; logic [31:0] d;} rsp_t;
  rsp_t sb_q[$];
  logic vld_exp = 1'b0;
  bit   mon_en = 1'b0;

  typedef struct {bit rd; logic [1:0] a; logic [31:0] d; int rep;} vec_t;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // read_vld must follow read_en by exactly one cycle; responses come off the scoreboard
  always @(posedge aclk) vld_exp <= read_en;
  always @(negedge aclk) begin
    if (mon_en) begin
      chk("rd_vld_timing", 64'(read_vld), 64'(vld_exp));
      if (read_vld) begin
        if (sb_q.size() == 0) begin
          chk("rd_unexpected", 64'd1, 64'd0);
        end else begin
          rsp_t r;
          r = sb_q.pop_front();
          chk($sformatf("rd_data_reg%0d", r.a), 64'(read_data), 64'(r.d));
        end
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    write_en = 1'b1; write_addr = {28'd0, a, 2'b00}; write_data = d;
    @(negedge aclk);
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    rsp_t r;
    r.a = a; r.d = e;
    sb_q.push_back(r);
    read_en = 1'b1; read_addr = {28'd0, a, 2'b00};
    @(negedge aclk);
    read_en = 1'b0;
  endtask

  function automatic logic sel(input int k);
    return (k == 2) ? i2s_bclk : i2s_lrclk;
  endfunction

  // kind 0: lrclk rise, 1: lrclk fall, 2: bclk fall
  task automatic wait_edge(input int kind, input int bound, input string nm);
    logic p, c;
    bit ok;
    ok = 1'b0;
    p = sel(kind);
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge aclk);
      c = sel(kind);
      if (kind == 0 ? (!p && c) : (p && !c)) ok = 1'b1;
      p = c;
    end
    chk(nm, 64'(ok), 64'd1);
  endtask

  // Sample sdata/lrclk on bclk rising edges, as the receiver does
  task automatic capture(input int nbits, input bit need_fall,
                         output logic [63:0] sd, output logic [63:0] lr, output int per);
    logic p;
    bit armed;
    int got, r1, r2;
    got = 0; r1 = 0; r2 = 0;
    armed = !need_fall; p = i2s_bclk; sd = 64'h0; lr = 64'h0;
    for (int c = 0; c < 2000 && got < nbits; c++) begin
      @(negedge aclk);
      if (p && !i2s_bclk) armed = 1'b1;
      else if (!p && i2s_bclk && armed) begin
        sd = {sd[62:0], i2s_sdata};
        lr = {lr[62:0], i2s_lrclk};
        if (got == 0) r1 = c;
        else if (got == 1) r2 = c;
        got++;
      end
      p = i2s_bclk;
    end
    chk("capture_done", 64'(got), 64'(nbits));
    per = r2 - r1;
  endtask

  initial begin
    vec_t tbl[15];
    logic [63:0] sd, lr;
    int per, highs;

    tbl[0]  = '{1'b1, 2'd1, 32'h0000_0001, 1};
    tbl[1]  = '{1'b1, 2'd0, 32'h0000_0000, 1};
    tbl[2]  = '{1'b1, 2'd2, 32'h0000_0000, 1};
    tbl[3]  = '{1'b0, 2'd2, 32'h0000_01FF, 1};
    tbl[4]  = '{1'b1, 2'd2, 32'h0000_00FF, 1};
    tbl[5]  = '{1'b0, 2'd0, 32'h0000_0004, 1};
    tbl[6]  = '{1'b1, 2'd0, (IRQ_ON ? 32'h0000_0004 : 32'h0000_0000), 1};
    tbl[7]  = '{1'b0, 2'd0, 32'h0000_0000, 1};
    tbl[8]  = '{1'b1, 2'd3, 32'h0000_0000, 1};
    tbl[9]  = '{1'b0, 2'd3, 32'h0000_0100, 17};
    tbl[10] = '{1'b1, 2'd1, 32'h0000_100A, 1};
    tbl[11] = '{1'b0, 2'd1, 32'h0000_0008, 1};
    tbl[12] = '{1'b1, 2'd1, 32'h0000_1002, 1};
    tbl[13] = '{1'b0, 2'd0, 32'h0000_0002, 1};
    tbl[14] = '{1'b1, 2'd1, 32'h0000_0001, 1};

    rst = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_bclk", 64'(i2s_bclk), 64'd0);
    chk("rst_lrclk", 64'(i2s_lrclk), 64'd0);
    chk("rst_sdata", 64'(i2s_sdata), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_read_vld", 64'(read_vld), 64'd0);
    chk("rst_read_data", 64'(read_data), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Register map, FIFO fill/overflow, W1C and flush
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < tbl[i].rep; k++) begin
        if (tbl[i].rd) rd(tbl[i].a, tbl[i].d);
        else           wr(tbl[i].a, tbl[i].d + 32'(k));
      end
    end

    // One sample then underrun: left/right bits, word select, BCLK period
    wr(2'd2, 32'h1);
    wr(2'd3, 32'hA5A5_3C3C);
    wr(2'd0, 32'h1);
    capture(64, 1'b1, sd, lr, per);
    chk("bclk_period", 64'(per), 64'd4);
    chk("sdata_two_frames", sd, 64'hA5A5_3C3C_0000_0000);
    chk("lrclk_two_frames", lr, 64'h0001_FFFE_0001_FFFE);
    rd(2'd1, 32'h0000_0005);

    // Push landing on the same edge as the b=0 pop keeps LEVEL at 1
    wait_edge(0, 300, "wait_lr_rise");
    wr(2'd1, 32'h4);
    wr(2'd3, 32'h1234_5678);
    wait_edge(1, 300, "wait_lr_fall");
    repeat (3) @(negedge aclk);
    wr(2'd3, 32'h9ABC_DEF0);
    rd(2'd1, 32'h0000_0100);
    capture(32, 1'b0, sd, lr, per);
    chk("popped_frame", sd, 64'h0000_0000_1234_5678);

    // EN cleared at b=10: frame runs to b=31, then engine idles
    wait_edge(1, 300, "wait_lr_fall2");
    for (int i = 0; i < 11; i++) wait_edge(2, 20, "wait_bclk_fall");
    wr(2'd0, 32'h0);
    wait_edge(0, 200, "frame_reaches_b15");
    wait_edge(1, 200, "frame_reaches_b31");
    repeat (2) @(negedge aclk);
    chk("b31_bclk_high", 64'(i2s_bclk), 64'd1);
    repeat (2) @(negedge aclk);
    chk("idle_bclk", 64'(i2s_bclk), 64'd0);
    chk("idle_lrclk", 64'(i2s_lrclk), 64'd0);
    chk("idle_sdata", 64'(i2s_sdata), 64'd0);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (i2s_bclk) highs++;
    end
    chk("idle_bclk_quiet", 64'(highs), 64'd0);

    // Reset at b=5 of a frame of ones
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 6; i++) wait_edge(2, 20, "wait_bclk_fall_b5");
    repeat (2) @(negedge aclk);
    chk("b5_bclk", 64'(i2s_bclk), 64'd1);
    chk("b5_sdata", 64'(i2s_sdata), 64'd1);
    rst = 1'b1;
    @(negedge aclk);
    chk("midrst_bclk", 64'(i2s_bclk), 64'd0);
    chk("midrst_lrclk", 64'(i2s_lrclk), 64'd0);
    chk("midrst_sdata", 64'(i2s_sdata), 64'd0);
    chk("midrst_irq", 64'(irq), 64'd0);
    rst = 1'b0;
    rd(2'd1, 32'h0000_0001);
    rd(2'd2, 32'h0000_0000);

    // Interrupt on LEVEL 9 -> 8 while enabled and masked in
    for (int i = 0; i < 9; i++) wr(2'd3, 32'h1000 + 32'(i));
    wr(2'd0, 32'h5);
    chk("irq_level9", 64'(irq), 64'd0);
    wait_edge(2, 20, "wait_first_pop");
    chk("irq_same_cycle", 64'(irq), 64'd0);
    @(negedge aclk);
    chk("irq_level8", 64'(irq), 64'(IRQ_ON));
    wr(2'd0, 32'h0);

    repeat (3) @(negedge aclk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
